// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared core definitions for the rvcpu front end: the data-path
//            width, the canonical NOP encoding and the fetch->decode
//            pipeline register layout {pc, inst}.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  // Fetch -> decode pipeline register
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_id_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with synchronous flush and occupancy count.
//            Push and pop may occur together (also when full). Flush wins
//            over push in the same cycle.
// Ports    : clk, reset        - clock / asynchronous active-high reset
//            flush             - empty the FIFO at the next edge
//            push, push_data   - write request and data
//            pop               - read request (head advances)
//            pop_data          - current head entry
//            count             - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  // A full FIFO may still accept a write when the head leaves this cycle.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = storage[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

`ifndef SYNTHESIS
  // Callers guarantee space; a dropped write is a design error upstream.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop && !flush));
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch front end. Issues in-order word fetches,
//            pairs responses with their PCs through a tag FIFO, buffers
//            instructions for decode and squashes in-flight/queued work on
//            a writeback redirect.
// Ports    : clk, reset                       - clock / async active-high reset
//            redirect_valid, redirect_pc      - branch hazard and new PC
//            imem_req_valid/ready/addr        - instruction memory request
//            imem_resp_valid/data             - in-order memory response
//            inst_valid/ready, inst_pc/data   - head entry toward decode
// Options  : FETCH_TRACE_EN - per-cycle "IF STAGE" trace print
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   outstanding;   // tag FIFO occupancy == fetches in flight
  logic [CW-1:0]   drop_cnt;      // in-flight responses still to be discarded
  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            resp_live;
  logic            inst_pop;
  logic [XLEN-1:0] tag_pc;
  if_id_t          q_push_data;
  if_id_t          q_head;

  // In-flight plus queued work never exceeds the queue size, so every
  // response that survives the drop counter always finds a free slot.
  assign occupancy      = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = !reset && !redirect_valid && (occupancy < DEPTH_W);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_live      = imem_resp_valid && (drop_cnt == '0);
  assign inst_valid     = (q_count != '0);
  assign inst_pop       = inst_valid && inst_ready;

  assign q_push_data.pc   = tag_pc;
  assign q_push_data.inst = imem_resp_data;
  assign inst_pc          = q_head.pc;
  assign inst_data        = q_head.inst;

  // Every response, live or stale, retires its tag.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (QUEUE_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (imem_resp_valid),
    .pop_data  (tag_pc),
    .count     (outstanding)
  );

  // A redirect flushes the queue, which also discards a live response
  // landing in the same cycle.
  sync_fifo #(
    .WIDTH ($bits(if_id_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_live),
    .push_data (q_push_data),
    .pop       (inst_pop),
    .pop_data  (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (req_fire) begin
      pc <= pc + 32'd4;
    end
  end

  // No request issues in a redirect cycle, so what remains in flight after
  // this edge is the tag count minus whatever response retires now; all of
  // it belongs to the squashed path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= outstanding - CW'(imem_resp_valid);
    end else if (imem_resp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    $display("IF STAGE");
    $display("  pc=%h req v/r/addr=%b/%b/%h resp v/data=%b/%h", pc,
             imem_req_valid, imem_req_ready, imem_req_addr,
             imem_resp_valid, imem_resp_data);
    $display("  count=%0d outstanding=%0d drop=%0d redirect v/pc=%b/%h",
             q_count, outstanding, drop_cnt, redirect_valid, redirect_pc);
    $display("  inst v/pc/data=%b/%h/%h", inst_valid, inst_pc, inst_data);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A program-order reference
//            (epoch-tagged fetch stream, queue of expected decode entries)
//            and a fixed-latency memory model drive directed and random
//            phases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  fetch_stage #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_pc         (inst_pc),
    .inst_data       (inst_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t        pending[$];   // accepted, response not yet delivered
  ent_t        expq[$];      // what decode should see, head first
  int          epoch = 0;
  int          cycle_n = 0;
  int          lat = 1;
  logic [31:0] exp_req_pc = 32'h0;
  logic [31:0] salt;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, advance the reference model with
  // the events that the next rising edge commits, then drive the memory.
  task automatic cycle();
    logic exp_rv;
    logic acc;
    logic pop;
    req_t r;
    ent_t e;
    @(negedge clk);
    exp_rv = !redirect_valid && ((pending.size() + expq.size()) < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, exp_req_pc);
    chk("inst_valid", 32'(inst_valid), 32'(expq.size() != 0));
    if (expq.size() != 0) begin
      chk("inst_pc", inst_pc, expq[0].pc);
      chk("inst_data", inst_data, expq[0].data);
    end
    acc = exp_rv && imem_req_ready;
    pop = (expq.size() != 0) && inst_ready;
    if (pop) e = expq.pop_front();
    if (imem_resp_valid) begin
      r = pending.pop_front();
      if (r.epoch == epoch && !redirect_valid)
        expq.push_back('{pc: r.addr, data: mem_word(r.addr)});
    end
    if (redirect_valid) begin
      expq.delete();
      epoch++;
      exp_req_pc = redirect_pc;
    end
    if (acc) begin
      pending.push_back('{addr: exp_req_pc, epoch: epoch, due: cycle_n + lat});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cycle_n++;
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (pending.size() != 0 && pending[0].due == cycle_n) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pending[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    inst_ready     = 1'b1;
    for (int i = 0; i < 40 && (pending.size() != 0 || expq.size() != 0); i++) cycle();
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
  endtask

  initial begin
    bit found;
    salt = $urandom;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Streaming: always ready, 1-cycle latency
    lat = 1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    run(12);

    // Decode stall fills the queue; requests stop at DEPTH
    inst_ready = 1'b0;
    run(5);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_inst_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    run(8);

    // Memory back-pressure at pc 0x10
    drain();
    redirect_to(32'h10);
    imem_req_ready = 1'b0;
    run(3);
    imem_req_ready = 1'b1;
    run(6);

    // Squash two in-flight fetches (3-cycle latency)
    drain();
    lat = 3;
    redirect_to(32'h8);
    imem_req_ready = 1'b1;
    run(2);
    redirect_to(32'h200);
    run(14);

    // Redirect coinciding with a live response and a decode pop
    drain();
    lat = 2;
    redirect_to(32'h40);
    imem_req_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_resp_valid && pending[0].epoch == epoch && expq.size() != 0) begin
        found = 1'b1;
        redirect_to(32'h300);
      end else begin
        cycle();
      end
    end
    run(10);

    // PC wrap past 0xFFFF_FFFC
    drain();
    lat = 1;
    redirect_to(32'hFFFF_FFF8);
    imem_req_ready = 1'b1;
    run(8);

    // Randomized traffic with redirects (including misaligned targets)
    for (int seg = 0; seg < 4; seg++) begin
      drain();
      lat = int'($urandom_range(1, 3));
      for (int i = 0; i < 80; i++) begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        inst_ready     = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 19) == 0) begin
          redirect_valid = 1'b1;
          redirect_pc    = $urandom;
        end
        cycle();
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
